// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier that borrows the shared ALU for each add via req/gnt.
module alu_mul_seq #(
    parameter int WIDTH      = 32,
    parameter int CNT_W      = 6,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_z
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic run, xc;
    assign run     = state_q == RUN;
    assign xc      = (cnt_q == CNT_W'(WIDTH)) || (EARLY_EXIT && mplier_q == '0);
    assign busy    = state_q != IDLE;
    assign done    = state_q == DONE;
    assign alu_req = run && !xc;
    assign alu_a   = run ? acc_q : '0;
    assign alu_b   = run ? mcand_q : '0;
    assign alu_op  = alu_req ? 3'b010 : 3'b000;
    assign result  = result_q;
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (state_q == IDLE && start) begin
            state_d  = RUN;
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
        end else if (run && xc) begin
            state_d  = DONE;
            result_d = acc_q;
        end else if (alu_req && alu_gnt) begin
            // one multiplier bit retires per granted ALU cycle; stalls simply hold
            acc_d    = mplier_q[0] ? alu_z : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed multiplies checked every cycle against a product-level model of the sequencer.
module tb_alu_mul_seq;
    localparam int W = 32;
    logic clk, rst_n, start, busy, done, alu_req, alu_gnt;
    logic [W-1:0] a, b, result, alu_a, alu_b, alu_z;
    logic [2:0] alu_op;
    int n_vec = 0, n_err = 0, cyc = 0;

    alu_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .alu_req(alu_req), .alu_gnt(alu_gnt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z)
    );

    assign alu_z = alu_a + alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_req"}, alu_req, 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_result"}, result, 0);
    endtask

    // Model: phase 0 idle, 1 iterating, 2 done; k = bits retired, n = bits needed.
    int m_ph = 0, m_k = 0, m_n = 0;
    logic [W-1:0] m_a = 0, m_b = 0, m_res = 0, e_acc, e_mask;
    logic e_req;

    function automatic int iters(input logic [W-1:0] bv);
        int r = 0;
        for (int i = 0; i < W; i++) if (bv[i]) r = i + 1;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ph = 0; m_k = 0; m_n = 0; m_a = 0; m_b = 0; m_res = 0;
            chk_zero("reset");
        end else begin
            e_mask = (m_k >= W) ? '1 : ((32'd1 << m_k) - 32'd1);
            e_acc  = m_a * (m_b & e_mask);
            e_req  = (m_ph == 1) && (m_k != m_n);
            chk("busy", busy, m_ph != 0);
            chk("done", done, m_ph == 2);
            chk("alu_req", alu_req, e_req);
            chk("alu_a", alu_a, m_ph == 1 ? e_acc : 0);
            chk("alu_b", alu_b, m_ph == 1 ? (m_a << m_k) : 0);
            chk("alu_op", alu_op, e_req ? 3'b010 : 3'b000);
            chk("result", result, m_res);
            if (m_ph == 0 && start) begin
                m_a = a; m_b = b; m_k = 0; m_n = iters(b); m_ph = 1;
            end else if (m_ph == 1) begin
                if (!e_req) begin
                    m_ph = 2; m_res = m_a * m_b;
                end else if (alu_gnt) m_k++;
            end else if (m_ph == 2) m_ph = 0;
        end
    end

    // gnt toggling starts with 0 in cycle 1, so grants fall on even cycles
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit tog,
                          input bit hold, input int abort_at, output int dcyc, output bit req_seen);
        @(posedge clk); #1;
        a = av; b = bv; start = 1'b1; alu_gnt = 1'b1;
        @(posedge clk); cyc = 1; #1;
        if (hold) begin a = av ^ 32'h5A5A_5A5A; b = 32'd9; end else start = 1'b0;
        alu_gnt = tog ? (cyc % 2 == 0) : 1'b1;
        dcyc = -1; req_seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (cyc == abort_at) begin
                #1 rst_n = 1'b0;
                #1 chk_zero("async_rst_run");
            end
            @(negedge clk);
            req_seen |= alu_req;
            if (done) begin dcyc = cyc; break; end
            @(posedge clk); cyc++; #1;
            alu_gnt = tog ? (cyc % 2 == 0) : 1'b1;
            rst_n = 1'b1;
        end
        @(posedge clk); cyc++; #1;
        start = 1'b0; alu_gnt = 1'b1;
    endtask

    int d;
    bit r;
    initial begin
        start = 0; a = 0; b = 0; alu_gnt = 0; rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_zero("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op(32'd7, 32'd6, 0, 0, -1, d, r);
        chk("t2_done_cycle", d, 5);
        chk("t2_result", result, 42);
        @(negedge clk);
        chk("t2_busy_after", busy, 0);
        chk("t2_result_held", result, 42);

        @(posedge clk); #2 rst_n = 1'b0;
        #1 chk_zero("async_rst_idle");
        @(posedge clk); #1 rst_n = 1'b1;

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, -1, d, r);
        chk("t3_done_cycle", d, 34);
        chk("t3_result", result, 32'h0000_0001);

        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1, 0, -1, d, r);
        chk("t4_done_cycle", d, 66);
        chk("t4_result", result, 32'h242D_2080);

        run_op(32'd11, 32'd0, 0, 1, -1, d, r);
        chk("t5_done_cycle", d, 2);
        chk("t5_req_seen", r, 0);
        @(negedge clk);
        chk("t5_result_kept", result, 0);
        chk("t5_not_restarted", busy, 0);

        run_op(32'd7, 32'd6, 0, 0, 3, d, r);
        chk("t6_no_done", d, 32'hFFFF_FFFF);
        chk("t6_result_cleared", result, 0);
        run_op(32'd3, 32'd5, 0, 0, -1, d, r);
        chk("t6_done_cycle", d, 5);
        chk("t6_result", result, 15);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
